ckegen_multi: RTL and testbench

//  Multi-channel, runtime-programmable clock-enable generator. Each of N_CH channels

---
 rtl/ckegen_multi.sv | 94 +++++++++
 tb/tb_ckegen_multi.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/ckegen_multi.sv
// ckegen_multi: N_CH runtime-programmable clock-enable channels (pulse or ~50 % square),
// all divided from one system clock and phase-alignable with a common sync.
module ckegen_multi #(
    parameter int unsigned  N_CH     = 4,
    parameter int unsigned  W        = 32,
    parameter logic [W-1:0] DIV_RST  = W'(50000000),
    parameter logic         MODE_RST = 1'b0,
    parameter logic         EN_RST   = 1'b1
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      cfg_we,
    input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] cfg_ch,
    input  logic [W-1:0]                              cfg_div,
    input  logic                                      cfg_mode,
    input  logic                                      cfg_en,
    input  logic                                      sync,
    output logic [W-1:0]                              cfg_rdiv,
    output logic [N_CH-1:0]                           cke
);

    localparam int unsigned   CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [CH_W:0] N_CH_L = (CH_W + 1)'(N_CH);

    logic [N_CH-1:0][W-1:0] div_q, div_d;
    logic [N_CH-1:0][W-1:0] cnt_q, cnt_d;
    logic [N_CH-1:0]        mode_q, mode_d;
    logic [N_CH-1:0]        en_q, en_d;
    logic [N_CH-1:0][W-1:0] eff_div;
    logic [N_CH-1:0][W:0]   half_cnt;
    logic [N_CH-1:0]        cke_raw;
    logic                   cfg_hit;

    // Out-of-range channel indices must not touch any channel.
    assign cfg_hit = cfg_we && ({1'b0, cfg_ch} < N_CH_L);

    always_comb begin
        div_d  = div_q;
        mode_d = mode_q;
        en_d   = en_q;
        for (int i = 0; i < int'(N_CH); i++) begin
            eff_div[i] = (div_q[i] == '0) ? W'(1) : div_q[i];
            // W+1 bits so ceil(d/2) cannot overflow for d = 2**W-1.
            half_cnt[i] = ({1'b0, eff_div[i]} + (W + 1)'(1)) >> 1;
            if (!en_q[i] || (cnt_q[i] >= eff_div[i] - W'(1))) begin
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + W'(1);
            end
            if (mode_q[i]) begin
                cke_raw[i] = en_q[i] && ({1'b0, cnt_q[i]} < half_cnt[i]);
            end else begin
                cke_raw[i] = en_q[i] && (cnt_q[i] == '0);
            end
        end
        if (sync) begin
            cnt_d = '0;
        end
        if (cfg_hit) begin
            div_d[cfg_ch]  = cfg_div;
            mode_d[cfg_ch] = cfg_mode;
            en_d[cfg_ch]   = cfg_en;
            cnt_d[cfg_ch]  = '0;
        end
    end

    always_comb begin
        cfg_rdiv = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            if (cfg_ch == CH_W'(i)) begin
                cfg_rdiv = div_q[i];
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every channel samples the
    // same pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q  <= {N_CH{DIV_RST}};
            mode_q <= {N_CH{MODE_RST}};
            en_q   <= {N_CH{EN_RST}};
            cnt_q  <= '0;
        end else begin
            div_q  <= div_d;
            mode_q <= mode_d;
            en_q   <= en_d;
            cnt_q  <= cnt_d;
        end
    end

    assign cke = rst ? '0 : cke_raw;

endmodule

// File: tb/tb_ckegen_multi.sv
// Directed, table-driven bench for ckegen_multi (3 channels, 16-bit dividers, reset divider 4).
module tb_ckegen_multi;

    localparam int N_CH = 3;
    localparam int W    = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_we;
    logic [1:0]    cfg_ch;
    logic [W-1:0]  cfg_div;
    logic          cfg_mode;
    logic          cfg_en;
    logic          sync;
    logic [W-1:0]  cfg_rdiv;
    logic [N_CH-1:0] cke;

    int n_cmp  = 0;
    int n_fail = 0;

    ckegen_multi #(
        .N_CH    (N_CH),
        .W       (W),
        .DIV_RST (16'd4),
        .MODE_RST(1'b0),
        .EN_RST  (1'b1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .cfg_we  (cfg_we),
        .cfg_ch  (cfg_ch),
        .cfg_div (cfg_div),
        .cfg_mode(cfg_mode),
        .cfg_en  (cfg_en),
        .sync    (sync),
        .cfg_rdiv(cfg_rdiv),
        .cke     (cke)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          we;
        logic [1:0]    ch;
        logic [W-1:0]  div;
        logic          mode;
        logic          en;
        logic          sync;
        logic [N_CH-1:0] exp_cke;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic we, input logic [1:0] ch, input logic [W-1:0] div,
                       input logic mode, input logic en, input logic sy,
                       input logic [N_CH-1:0] exp_cke);
        vec_t v;
        v.we = we; v.ch = ch; v.div = div; v.mode = mode; v.en = en; v.sync = sy;
        v.exp_cke = exp_cke;
        vecs.push_back(v);
    endtask

    task automatic idle(input logic [N_CH-1:0] exp_cke);
        add(1'b0, 2'd0, '0, 1'b0, 1'b0, 1'b0, exp_cke);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        cfg_we = 1'b0; cfg_ch = 2'd0; cfg_div = '0; cfg_mode = 1'b0; cfg_en = 1'b0; sync = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();

        // Vectors: inputs applied before an edge, expected cke {ch2,ch1,ch0} in the cycle after.
        // Default period 4, pulse, all enabled.
        idle(3'b000); idle(3'b000); idle(3'b000); idle(3'b111); idle(3'b000);
        // ch1 -> div 5 square: 1,1,1,0,0
        add(1'b1, 2'd1, 16'd5, 1'b1, 1'b1, 1'b0, 3'b010);
        idle(3'b010); idle(3'b111); idle(3'b000); idle(3'b000); idle(3'b010); idle(3'b111);
        // div 0 / div 1 in both modes, div 2 square
        add(1'b1, 2'd0, 16'd0, 1'b0, 1'b1, 1'b0, 3'b011);
        add(1'b1, 2'd2, 16'd1, 1'b1, 1'b1, 1'b0, 3'b101);
        add(1'b1, 2'd1, 16'd2, 1'b1, 1'b1, 1'b0, 3'b111);
        idle(3'b101); idle(3'b111);
        add(1'b1, 2'd1, 16'd0, 1'b1, 1'b1, 1'b0, 3'b111);
        add(1'b1, 2'd2, 16'd1, 1'b0, 1'b1, 1'b0, 3'b111);
        idle(3'b111);
        // ch0 div 3, ch1 div 4 out of phase, ch2 disabled, then sync
        add(1'b1, 2'd0, 16'd3, 1'b0, 1'b1, 1'b0, 3'b111);
        add(1'b1, 2'd1, 16'd4, 1'b0, 1'b1, 1'b0, 3'b110);
        add(1'b1, 2'd2, 16'd7, 1'b0, 1'b0, 1'b0, 3'b000);
        idle(3'b001); idle(3'b000); idle(3'b010);
        add(1'b0, 2'd0, '0, 1'b0, 1'b0, 1'b1, 3'b011);
        idle(3'b000); idle(3'b000); idle(3'b001); idle(3'b010); idle(3'b000); idle(3'b001);
        // invalid channel write: nothing changes
        add(1'b1, 2'd3, 16'd9, 1'b1, 1'b0, 1'b0, 3'b000);

        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("rst_cke_%0d", i), 32'(cke), 32'h0);
        end
        for (int c = 0; c < N_CH; c++) begin
            cfg_ch = 2'(c);
            #1;
            check($sformatf("rst_rdiv_ch%0d", c), 32'(cfg_rdiv), 32'd4);
        end
        cfg_ch = 2'd0;
        rst = 1'b0;
        #1;
        check("release_cycle0", 32'(cke), 32'b111);

        for (int i = 0; i < vecs.size(); i++) begin
            cfg_we = vecs[i].we; cfg_ch = vecs[i].ch; cfg_div = vecs[i].div;
            cfg_mode = vecs[i].mode; cfg_en = vecs[i].en; sync = vecs[i].sync;
            tick();
            clear_inputs();
            check($sformatf("vec%0d_cke", i), 32'(cke), 32'(vecs[i].exp_cke));
        end

        // Dividers survive the invalid write.
        cfg_ch = 2'd0; #1; check("rdiv_ch0_after_bad_wr", 32'(cfg_rdiv), 32'd3);
        cfg_ch = 2'd1; #1; check("rdiv_ch1_after_bad_wr", 32'(cfg_rdiv), 32'd4);
        cfg_ch = 2'd2; #1; check("rdiv_ch2_after_bad_wr", 32'(cfg_rdiv), 32'd7);
        cfg_ch = 2'd0;

        // Continue: ch0 at cnt1, ch1 at cnt3 after the invalid write cycle.
        tick(); check("post_bad_wr", 32'(cke), 32'b010);
        // Same-cycle sync and write to ch0 (div 5).
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 16'd5; cfg_en = 1'b1; sync = 1'b1;
        tick(); clear_inputs();
        check("sync_wr_c0", 32'(cke), 32'b011);
        cfg_ch = 2'd0; #1; check("sync_wr_rdiv", 32'(cfg_rdiv), 32'd5);
        tick(); check("sync_wr_c1", 32'(cke), 32'b000);
        tick(); check("sync_wr_c2", 32'(cke), 32'b000);
        tick(); check("sync_wr_c3", 32'(cke), 32'b000);
        tick(); check("sync_wr_c4", 32'(cke), 32'b010);
        tick(); check("sync_wr_c5", 32'(cke), 32'b001);

        // Disable ch1 in the cycle before its pulse, then re-enable.
        tick(); check("pre_dis_a", 32'(cke), 32'b000);
        tick(); check("pre_dis_b", 32'(cke), 32'b000);
        cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 16'd4; cfg_en = 1'b0;
        tick(); clear_inputs();
        check("disabled_no_pulse", 32'(cke), 32'b000);
        tick(); check("disabled_hold", 32'(cke), 32'b000);
        tick(); check("disabled_ch0_pulse", 32'(cke), 32'b001);
        cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 16'd4; cfg_en = 1'b1;
        tick(); clear_inputs();
        check("reenable_pulse", 32'(cke), 32'b010);
        tick(); check("reenable_next", 32'(cke), 32'b000);

        // ch2 square div 6, then reset while it is high.
        cfg_we = 1'b1; cfg_ch = 2'd2; cfg_div = 16'd6; cfg_mode = 1'b1; cfg_en = 1'b1;
        tick(); clear_inputs();
        check("sq6_c0", 32'(cke), 32'b100);
        tick(); check("sq6_c1", 32'(cke), 32'b100);
        rst = 1'b1;
        #1; check("rst_mid_square", 32'(cke), 32'h0);
        tick(); check("rst_held", 32'(cke), 32'h0);
        cfg_ch = 2'd2; #1; check("rst_rdiv_default", 32'(cfg_rdiv), 32'd4);
        cfg_ch = 2'd0;
        rst = 1'b0;
        #1; check("rerelease_c0", 32'(cke), 32'b111);
        tick(); check("rerelease_c1", 32'(cke), 32'b000);
        tick(); check("rerelease_c2", 32'(cke), 32'b000);
        tick(); check("rerelease_c3", 32'(cke), 32'b000);
        tick(); check("rerelease_c4", 32'(cke), 32'b111);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
